lag_meter: RTL and testbench

- Downstream consumer of the video timing generator's `starttrigger` pulse, which marks the first active pixel of a frame in which the white measurement fields turn on.
- Samples an asynchronous photodiode/sensor input, synchronises and debounces it, and measures the number of `clock` cycles from trigger to detected brightness.
- Publishes each latency result plus running min/max/count statistics, and flags timeouts and missed triggers.
- Runs in the pixel-clock domain, next to the video generator.

---
 rtl/lag_meter_pkg.sv | 23 ++
 rtl/lag_meter_if.sv | 31 +++
 rtl/lag_meter_sensor_filter.sv | 57 +++++
 rtl/lag_meter.sv | 144 ++++++++++++++
 tb/tb_lag_meter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lag_meter_pkg.sv
// lag_meter_pkg: shared types and constants for the display-lag meter.
//   LagState  - measurement FSM states
//   LagResult - latency + statistics bundle for OSD / host readout
package lag_meter_pkg;

    localparam int unsigned LAG_SYNC_STAGES  = 2;
    localparam int unsigned LAG_COUNT_WIDTH  = 32;
    localparam int unsigned LAG_SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } LagState;

    typedef struct packed {
        logic [LAG_COUNT_WIDTH-1:0]  latency;
        logic [LAG_COUNT_WIDTH-1:0]  min;
        logic [LAG_COUNT_WIDTH-1:0]  max;
        logic [LAG_SAMPLE_WIDTH-1:0] count;
    } LagResult;

endpackage

// File: rtl/lag_meter_if.sv
// lag_meter_if: trigger/sensor inputs and result/statistics outputs of the
// lag meter. master = video generator / host side, slave = lag_meter.
interface lag_meter_if
    import lag_meter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
);
    logic                        starttrigger;
    logic                        sensor_in;
    logic                        clear_stats;
    logic                        busy;
    logic [COUNT_WIDTH-1:0]      result_latency;
    logic                        result_valid;
    logic                        timeout;
    logic                        missed;
    logic [COUNT_WIDTH-1:0]      lat_min;
    logic [COUNT_WIDTH-1:0]      lat_max;
    logic [LAG_SAMPLE_WIDTH-1:0] sample_count;

    modport master (
        output starttrigger, sensor_in, clear_stats,
        input  busy, result_latency, result_valid, timeout, missed,
               lat_min, lat_max, sample_count
    );

    modport slave (
        input  starttrigger, sensor_in, clear_stats,
        output busy, result_latency, result_valid, timeout, missed,
               lat_min, lat_max, sample_count
    );
endinterface

// File: rtl/lag_meter_sensor_filter.sv
// sensor_filter: synchronises the raw sensor, normalises polarity so that
// filt=1 means light, and debounces it.
//   clock, reset - pixel clock, synchronous active-high reset
//   sensor_in    - raw asynchronous sensor level
//   filt         - debounced, active-high light level
module sensor_filter
    import lag_meter_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES      = 16,
    parameter bit          SENSOR_ACTIVE_HIGH = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor_in,
    output logic filt
);
    localparam int unsigned      RUN_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic             IDLE_RAW = !SENSOR_ACTIVE_HIGH;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(FILTER_CYCLES);

    // sync_q[0] is the first stage, the top bit the second
    logic [LAG_SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RUN_W-1:0]           run_q, run_d;
    logic                       filt_q, filt_d;
    logic                       level_c;

    // Filter flips only after the opposite level has been seen for the full run
    always_comb begin
        sync_d  = {sync_q[LAG_SYNC_STAGES-2:0], sensor_in};
        level_c = sync_q[LAG_SYNC_STAGES-1] ^ IDLE_RAW;
        run_d   = run_q;
        filt_d  = filt_q;
        if (level_c == filt_q) begin
            run_d = '0;
        end else if (run_q == RUN_MAX) begin
            filt_d = level_c;
            run_d  = '0;
        end else begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {LAG_SYNC_STAGES{IDLE_RAW}};
            run_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/lag_meter.sv
// lag_meter: measures clock cycles from the video generator's starttrigger
// to debounced sensor brightness, with running min/max/count statistics.
//   clock, reset - pixel clock, synchronous active-high reset
//   bus (slave)  - starttrigger, sensor_in, clear_stats in; busy,
//                  result_latency/valid, timeout, missed, lat_min/max,
//                  sample_count out
module lag_meter
    import lag_meter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH        = 32,
    parameter int unsigned FILTER_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 74250000,
    parameter bit          SENSOR_ACTIVE_HIGH = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    lag_meter_if.slave  bus
);
    // Pipeline delay from sync1 capture to filt being seen by the FSM
    localparam logic [COUNT_WIDTH-1:0] COMP        = COUNT_WIDTH'(FILTER_CYCLES + 2);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

    logic                        filt;
    LagState                     state_q, state_d;
    logic [COUNT_WIDTH-1:0]      cnt_q, cnt_d, cnt_inc_c, latency_c;
    logic [COUNT_WIDTH-1:0]      latency_q, latency_d;
    logic [COUNT_WIDTH-1:0]      lat_min_q, lat_min_d, lat_max_q, lat_max_d;
    logic [LAG_SAMPLE_WIDTH-1:0] count_q, count_d;
    logic                        valid_q, valid_d, timeout_q, timeout_d;
    logic                        missed_q, missed_d, busy_q, busy_d;
    logic                        new_result_c;

    sensor_filter #(
        .FILTER_CYCLES      (FILTER_CYCLES),
        .SENSOR_ACTIVE_HIGH (SENSOR_ACTIVE_HIGH)
    ) u_filter (
        .clock     (clock),
        .reset     (reset),
        .sensor_in (bus.sensor_in),
        .filt      (filt)
    );

    // Next-state, result and statistics logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latency_d    = latency_q;
        lat_min_d    = lat_min_q;
        lat_max_d    = lat_max_q;
        count_d      = count_q;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        missed_d     = 1'b0;
        new_result_c = 1'b0;
        cnt_inc_c    = cnt_q + COUNT_WIDTH'(1);
        // Clamp guards against a rise that started inside the filter window
        latency_c    = (cnt_q >= COMP) ? (cnt_q - COMP) : '0;

        case (state_q)
            IDLE: begin
                if (bus.starttrigger) begin
                    if (filt) begin
                        missed_d = 1'b1;
                    end else begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end
                end
            end
            ARMED: begin
                // Detection takes priority over a coincident timeout
                if (filt) begin
                    latency_d    = latency_c;
                    valid_d      = 1'b1;
                    new_result_c = 1'b1;
                    state_d      = HOLDOFF;
                end else begin
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == TIMEOUT_VAL) begin
                        timeout_d = 1'b1;
                        state_d   = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                missed_d = bus.starttrigger;
                if (!filt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear first so a coincident result is folded into fresh stats
        if (bus.clear_stats) begin
            lat_min_d = '1;
            lat_max_d = '0;
            count_d   = '0;
        end
        if (new_result_c) begin
            if (latency_c < lat_min_d) lat_min_d = latency_c;
            if (latency_c > lat_max_d) lat_max_d = latency_c;
            if (count_d != '1)         count_d   = count_d + LAG_SAMPLE_WIDTH'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            latency_q <= '0;
            lat_min_q <= '1;
            lat_max_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            missed_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latency_q <= latency_d;
            lat_min_q <= lat_min_d;
            lat_max_q <= lat_max_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            missed_q  <= missed_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.result_latency = latency_q;
    assign bus.result_valid   = valid_q;
    assign bus.timeout        = timeout_q;
    assign bus.missed         = missed_q;
    assign bus.lat_min        = lat_min_q;
    assign bus.lat_max        = lat_max_q;
    assign bus.sample_count   = count_q;

endmodule

// File: tb/tb_lag_meter.sv
// tb_lag_meter: scenario tasks driving lag_meter; expected results come from
// a sensor-history model (first run of FILTER_CYCLES+1 active samples) and
// plain min/max/count bookkeeping.
module tb_lag_meter;
    localparam int F  = 4;
    localparam int TO = 5000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    lag_meter_if #(.COUNT_WIDTH(32)) bus ();

    lag_meter #(
        .COUNT_WIDTH        (32),
        .FILTER_CYCLES      (F),
        .TIMEOUT_CYCLES     (TO),
        .SENSOR_ACTIVE_HIGH (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          sens_hist [int];
    int          rv_edges[$];
    logic [31:0] rv_lats[$];
    int          to_edges[$];
    int          ms_edges[$];
    logic [31:0] exp_min = '1;
    logic [31:0] exp_max = '0;
    int          exp_cnt = 0;
    logic [31:0] exp_lat = '0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // One clock: record the sensor level sampled at the coming edge, then log events
    task automatic tick();
        sens_hist[cyc + 1] = bus.sensor_in;
        @(posedge clock);
        #1;
        if (bus.result_valid) begin
            rv_edges.push_back(cyc);
            rv_lats.push_back(bus.result_latency);
        end
        if (bus.timeout) to_edges.push_back(cyc);
        if (bus.missed)  ms_edges.push_back(cyc);
    endtask

    task automatic clear_events();
        rv_edges.delete(); rv_lats.delete(); to_edges.delete(); ms_edges.delete();
    endtask

    // Brightness is detected at the first edge S after T0 that starts F+1
    // consecutive active samples; the result shows F+3 edges later.
    function automatic void model_detect(input int t0, output int det_edge,
                                         output int det_lat, output int to_edge);
        bit ok;
        det_edge = -1; det_lat = 0; to_edge = -1;
        for (int s = t0 + 1; s + F + 3 <= t0 + TO; s++) begin
            ok = 1'b1;
            for (int k = 0; k <= F; k++)
                if (!(sens_hist.exists(s + k) && sens_hist[s + k])) ok = 1'b0;
            if (ok) begin
                det_edge = s + F + 3;
                det_lat  = s - t0;
                return;
            end
        end
        to_edge = t0 + TO;
    endfunction

    task automatic check_stats(input string name);
        n_checks++; if (bus.lat_min !== exp_min) begin n_fail++; $display("FAIL %s lat_min got %0d need %0d", name, bus.lat_min, exp_min); end
        n_checks++; if (bus.lat_max !== exp_max) begin n_fail++; $display("FAIL %s lat_max got %0d need %0d", name, bus.lat_max, exp_max); end
        n_checks++; if (bus.sample_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL %s sample_count got %0d need %0d", name, bus.sample_count, exp_cnt); end
        n_checks++; if (bus.result_latency !== exp_lat) begin n_fail++; $display("FAIL %s result_latency got %0d need %0d", name, bus.result_latency, exp_lat); end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin tick(); n++; end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_release got %b need 0", name, bus.busy); end
    endtask

    // One measurement: trigger, optional glitch / re-trigger / clear, rise at T0+lat
    task automatic measure(input string name, input int lat, input int goff, input int glen,
                           input int rt, input bit clr, input bit ho_trig);
        int t0, e, last, det_edge, det_lat, to_edge, mt;
        clear_events();
        bus.starttrigger = 1'b1;
        tick();
        t0 = cyc;
        bus.starttrigger = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_armed got %b need 1", name, bus.busy); end
        last = t0 + lat + F + 3 + 4;
        while (cyc < last) begin
            e = cyc + 1;
            bus.sensor_in    = (e - t0 >= lat) || (glen > 0 && e - t0 >= goff && e - t0 < goff + glen);
            bus.starttrigger = (rt > 0 && e - t0 == rt);
            bus.clear_stats  = clr && (e == t0 + lat + F + 3);
            tick();
        end
        bus.starttrigger = 1'b0;
        bus.clear_stats  = 1'b0;
        model_detect(t0, det_edge, det_lat, to_edge);
        if (det_edge >= 0) begin
            if (clr) begin exp_min = '1; exp_max = '0; exp_cnt = 0; end
            exp_lat = 32'(det_lat);
            if (exp_lat < exp_min) exp_min = exp_lat;
            if (exp_lat > exp_max) exp_max = exp_lat;
            if (exp_cnt < 65535) exp_cnt++;
        end
        n_checks++; if (rv_edges.size() != 1) begin n_fail++; $display("FAIL %s result_valid_count got %0d need 1", name, rv_edges.size()); end
        if (rv_edges.size() > 0) begin
            n_checks++; if (rv_edges[0] != det_edge) begin n_fail++; $display("FAIL %s result_edge got T0+%0d need T0+%0d", name, rv_edges[0] - t0, det_edge - t0); end
            n_checks++; if (rv_lats[0] !== 32'(det_lat)) begin n_fail++; $display("FAIL %s latency got %0d need %0d", name, rv_lats[0], det_lat); end
        end
        n_checks++; if (to_edges.size() != 0 || ms_edges.size() != 0) begin n_fail++; $display("FAIL %s stray_pulses got timeout=%0d missed=%0d need 0/0", name, to_edges.size(), ms_edges.size()); end
        check_stats(name);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_holdoff got %b need 1", name, bus.busy); end
        if (ho_trig) begin
            bus.starttrigger = 1'b1;
            tick();
            mt = cyc;
            bus.starttrigger = 1'b0;
            tick();
            n_checks++; if (ms_edges.size() != 1 || ms_edges[0] != mt) begin n_fail++; $display("FAIL %s missed_holdoff got count=%0d need 1 at edge %0d", name, ms_edges.size(), mt); end
        end
        bus.sensor_in = 1'b0;
        wait_idle(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.starttrigger = 1'b0; bus.sensor_in = 1'b0; bus.clear_stats = 1'b0;
        repeat (3) tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.missed !== 1'b0)
            begin n_fail++; $display("FAIL reset_flags got busy=%b rv=%b to=%b ms=%b need 0000", bus.busy, bus.result_valid, bus.timeout, bus.missed); end
        check_stats("reset");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        measure("basic", 1000, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_glitch();
        measure("glitch", 2000, 700, F - 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int t0, det_edge, det_lat, to_edge;
        clear_events();
        bus.starttrigger = 1'b1;
        tick();
        t0 = cyc;
        bus.starttrigger = 1'b0;
        repeat (TO + 10) tick();
        model_detect(t0, det_edge, det_lat, to_edge);
        n_checks++; if (to_edges.size() != 1 || to_edges[0] != to_edge) begin n_fail++; $display("FAIL timeout_pulse got count=%0d need 1 at T0+%0d", to_edges.size(), to_edge - t0); end
        n_checks++; if (rv_edges.size() != 0) begin n_fail++; $display("FAIL timeout_no_result got %0d need 0", rv_edges.size()); end
        check_stats("timeout");
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle busy got %b need 0", bus.busy); end
    endtask

    task automatic test_missed();
        int t0;
        clear_events();
        bus.sensor_in = 1'b1;
        repeat (F + 10) tick();
        bus.starttrigger = 1'b1;
        tick();
        t0 = cyc;
        bus.starttrigger = 1'b0;
        repeat (3) tick();
        n_checks++; if (ms_edges.size() != 1 || ms_edges[0] != t0) begin n_fail++; $display("FAIL missed_idle got count=%0d need 1 at edge %0d", ms_edges.size(), t0); end
        n_checks++; if (bus.busy !== 1'b0 || rv_edges.size() != 0) begin n_fail++; $display("FAIL missed_stays_idle got busy=%b rv=%0d need 0/0", bus.busy, rv_edges.size()); end
        bus.sensor_in = 1'b0;
        repeat (F + 10) tick();
        measure("retrig_armed", 1500, 0, 0, 600, 1'b0, 1'b0);
    endtask

    task automatic test_stats();
        bus.clear_stats = 1'b1;
        tick();
        bus.clear_stats = 1'b0;
        exp_min = '1; exp_max = '0; exp_cnt = 0;
        check_stats("clear_only");
        measure("stats800", 800, 0, 0, 0, 1'b0, 1'b0);
        measure("stats1200", 1200, 0, 0, 0, 1'b0, 1'b0);
        measure("stats1000", 1000, 0, 0, 0, 1'b0, 1'b0);
        n_checks++; if (bus.lat_min !== 32'd800 || bus.lat_max !== 32'd1200 || bus.sample_count !== 16'd3)
            begin n_fail++; $display("FAIL stats_three got %0d/%0d/%0d need 800/1200/3", bus.lat_min, bus.lat_max, bus.sample_count); end
        measure("clear_on_result", 900, 0, 0, 0, 1'b1, 1'b0);
        n_checks++; if (bus.lat_min !== 32'd900 || bus.lat_max !== 32'd900 || bus.sample_count !== 16'd1)
            begin n_fail++; $display("FAIL stats_clear got %0d/%0d/%0d need 900/900/1", bus.lat_min, bus.lat_max, bus.sample_count); end
    endtask

    task automatic test_random();
        int lat, goff, glen, rt;
        bit clr;
        for (int i = 0; i < 4; i++) begin
            lat  = int'($urandom_range(2500, 40));
            goff = 0; glen = 0; rt = 0;
            if ($urandom_range(1, 0) == 1) begin
                glen = int'($urandom_range(F - 1, 1));
                goff = int'($urandom_range(lat - 15, 10));
            end
            if ($urandom_range(1, 0) == 1) rt = int'($urandom_range(lat - 1, 2));
            clr = ($urandom_range(3, 0) == 0);
            measure("random", lat, goff, glen, rt, clr, $urandom_range(1, 0) == 1);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        clear_events();
        bus.starttrigger = 1'b1;
        tick();
        t0 = cyc;
        bus.starttrigger = 1'b0;
        while (cyc < t0 + 299) tick();
        reset = 1'b1;
        tick();
        exp_min = '1; exp_max = '0; exp_cnt = 0; exp_lat = '0;
        n_checks++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.missed !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid_flags got busy=%b rv=%b to=%b ms=%b need 0000", bus.busy, bus.result_valid, bus.timeout, bus.missed); end
        check_stats("reset_mid");
        reset = 1'b0;
        bus.sensor_in = 1'b1;
        repeat (60) tick();
        n_checks++; if (rv_edges.size() != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_result got rv=%0d busy=%b need 0/0", rv_edges.size(), bus.busy); end
        bus.sensor_in = 1'b0;
        repeat (F + 10) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_timeout();
        test_missed();
        test_stats();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
